// File: rtl/arb4_rr_stage_pkg.sv
// Shared types and constants for the four-source round-robin arbiter stage.
// Used by rr_pick4 and arb4_rr_stage (optional burst lock: ARB4_BURST_LOCK_EN).
package kolum_arb_pkg;

   localparam int NUM_SRC = 4;
   localparam int SRC_W   = 2;

   typedef logic [SRC_W-1:0] src_idx_t;

   typedef enum logic [0:0] {
      LK_IDLE   = 1'b0,
      LK_LOCKED = 1'b1
   } lock_state_t;

   // Rotating source index; the 2-bit width gives the wrap from 3 back to 0.
   function automatic src_idx_t next_idx(input src_idx_t idx);
      return idx + src_idx_t'(1);
   endfunction

endpackage

// File: rtl/arb4_rr_stage_if.sv
// Four-source request bus plus one downstream valid/ready stream.
// The in_last flags exist only when ARB4_BURST_LOCK_EN is defined.
interface arb4_rr_stage_if #(
   parameter int DataWidth = 16
);
   logic [3:0]           in_valid;
   logic [DataWidth-1:0] in_data_0;
   logic [DataWidth-1:0] in_data_1;
   logic [DataWidth-1:0] in_data_2;
   logic [DataWidth-1:0] in_data_3;
   logic [3:0]           in_ready;
`ifdef ARB4_BURST_LOCK_EN
   logic [3:0]           in_last;
`endif
   logic                 out_valid;
   logic [DataWidth-1:0] out_data;
   logic [1:0]           out_src;
   logic                 out_ready;

   modport slave (
      input  in_valid, in_data_0, in_data_1, in_data_2, in_data_3,
`ifdef ARB4_BURST_LOCK_EN
      input  in_last,
`endif
      input  out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   modport master (
      output in_valid, in_data_0, in_data_1, in_data_2, in_data_3,
`ifdef ARB4_BURST_LOCK_EN
      output in_last,
`endif
      output out_ready,
      input  in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/arb4_rr_stage_rr_pick4.sv
// Combinational rotate-priority picker: first requester at or after ptr wins.
module rr_pick4
   import kolum_arb_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  src_idx_t           ptr,
   output src_idx_t           grant_idx,
   output logic               any_req
);
   src_idx_t idx;
   logic     found;

   always_comb begin
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      idx       = ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = ptr + src_idx_t'(k);
         if (!found && req[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux4_nbit.sv
// Plain 4:1 multiplexer of MuxWidth-bit words, select 0 picks in0.
module mux4_nbit #(
   parameter int MuxWidth = 16
) (
   input  logic [MuxWidth-1:0] in0,
   input  logic [MuxWidth-1:0] in1,
   input  logic [MuxWidth-1:0] in2,
   input  logic [MuxWidth-1:0] in3,
   input  logic [1:0]          sel,
   output logic [MuxWidth-1:0] out_y
);
   always_comb begin
      unique case (sel)
         2'd0:    out_y = in0;
         2'd1:    out_y = in1;
         2'd2:    out_y = in2;
         default: out_y = in3;
      endcase
   end
endmodule

// File: rtl/arb4_rr_stage.sv
// Round-robin 4:1 arbiter with a registered valid/ready output stage.
// Optional burst lock (source keeps the grant until in_last): ARB4_BURST_LOCK_EN.
module arb4_rr_stage
   import kolum_arb_pkg::*;
#(
   parameter int DataWidth = 16
) (
   input  logic clk,
   input  logic rst,
   arb4_rr_stage_if.slave bus
);
   logic                 out_valid_q, out_valid_d;
   logic [DataWidth-1:0] out_data_q, out_data_d;
   src_idx_t             out_src_q, out_src_d;
   src_idx_t             ptr_q, ptr_d;

   src_idx_t             pick_idx, grant_idx;
   logic                 pick_any, grant_any;
   logic                 can_load, xfer;
   logic [DataWidth-1:0] mux_out;

   rr_pick4 u_pick (
      .req       (bus.in_valid),
      .ptr       (ptr_q),
      .grant_idx (pick_idx),
      .any_req   (pick_any)
   );

   mux4_nbit #(.MuxWidth(DataWidth)) u_mux (
      .in0   (bus.in_data_0),
      .in1   (bus.in_data_1),
      .in2   (bus.in_data_2),
      .in3   (bus.in_data_3),
      .sel   (grant_idx),
      .out_y (mux_out)
   );

   // out_ready feeds straight through to in_ready so a full register can drain and refill in one cycle.
   assign can_load = !out_valid_q || bus.out_ready;

`ifdef ARB4_BURST_LOCK_EN
   lock_state_t lock_q, lock_d;
   src_idx_t    lock_idx_q, lock_idx_d;

   assign grant_idx = (lock_q == LK_LOCKED) ? lock_idx_q : pick_idx;
   assign grant_any = (lock_q == LK_LOCKED) ? bus.in_valid[lock_idx_q] : pick_any;
`else
   assign grant_idx = pick_idx;
   assign grant_any = pick_any;
`endif

   assign xfer = can_load && grant_any;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign bus.in_ready[gi] = xfer && (grant_idx == src_idx_t'(gi));
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_out;
         out_src_d   = grant_idx;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ARB4_BURST_LOCK_EN
   // The pointer only advances when a burst finishes, so a locked source cannot skip its turn order.
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         if (lock_q == LK_IDLE) begin
            if (!bus.in_last[grant_idx]) begin
               lock_d     = LK_LOCKED;
               lock_idx_d = grant_idx;
            end else begin
               ptr_d = next_idx(grant_idx);
            end
         end else if (bus.in_last[lock_idx_q]) begin
            lock_d = LK_IDLE;
            ptr_d  = next_idx(lock_idx_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q     <= LK_IDLE;
         lock_idx_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end
`else
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = next_idx(grant_idx);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb4_rr_stage.sv
// Directed bench for arb4_rr_stage: vector table plus hand-written multi-cycle sequences.
module tb_arb4_rr_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;

   arb4_rr_stage_if #(.DataWidth(16)) bus ();

   arb4_rr_stage #(.DataWidth(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] d0, d1, d2, d3;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [15:0] exp_od;
      logic [1:0]  exp_src;
   } vec_t;

   vec_t vecs [12];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d, input logic r);
      bus.in_valid  = v;
      bus.in_data_0 = a;
      bus.in_data_1 = b;
      bus.in_data_2 = c;
      bus.in_data_3 = d;
      bus.out_ready = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_in(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{4'b0100, 16'h0,    16'h0,    16'hBEEF, 16'h0,    1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
      vecs[1]  = '{4'b0000, 16'h0,    16'h0,    16'h0,    16'h0,    1'b1, 4'b0000, 1'b0, 16'hBEEF, 2'd2};
      vecs[2]  = '{4'b0011, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 1'b1, 4'b0001, 1'b1, 16'h00A0, 2'd0};
      vecs[3]  = '{4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b1, 4'b0010, 1'b1, 16'hC001, 2'd1};
      vecs[4]  = '{4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b1, 4'b0100, 1'b1, 16'hC002, 2'd2};
      vecs[5]  = '{4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b1, 4'b1000, 1'b1, 16'hC003, 2'd3};
      vecs[6]  = '{4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1'b1, 4'b0001, 1'b1, 16'hC000, 2'd0};
      vecs[7]  = '{4'b0001, 16'h5555, 16'h0,    16'h0,    16'h0,    1'b1, 4'b0001, 1'b1, 16'h5555, 2'd0};
      vecs[8]  = '{4'b0000, 16'h0,    16'h0,    16'h0,    16'h0,    1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0};
      vecs[9]  = '{4'b1111, 16'hD000, 16'hD001, 16'hD002, 16'hD003, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0};
      vecs[10] = '{4'b1111, 16'hD000, 16'hD001, 16'hD002, 16'hD003, 1'b1, 4'b0010, 1'b1, 16'hD001, 2'd1};
      vecs[11] = '{4'b0000, 16'h0,    16'h0,    16'h0,    16'h0,    1'b1, 4'b0000, 1'b0, 16'hD001, 2'd1};

      set_in(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
`ifdef ARB4_BURST_LOCK_EN
      bus.in_last = 4'b1111;
`endif
      #2;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data",  32'(bus.out_data),  32'd0);
      chk("reset out_src",   32'(bus.out_src),   32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table: single request, drain, wrap, fairness, stall, drain+load.
      for (int i = 0; i < 12; i++) begin
         set_in(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
         tick();
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d out_data", i),  32'(bus.out_data),  32'(vecs[i].exp_od));
         chk($sformatf("vec%0d out_src", i),   32'(bus.out_src),   32'(vecs[i].exp_src));
         $display("vec%0d valid=%b ready=%b out_valid=%b out_data=%h out_src=%0d",
                  i, vecs[i].valid, bus.in_ready, bus.out_valid, bus.out_data, bus.out_src);
      end

      // Fairness from reset: all four requesting, grants 0,1,2,3,0,1,2,3.
      do_reset();
      set_in(4'b1111, 16'd0, 16'd1, 16'd2, 16'd3, 1'b1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("fair%0d out_valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("fair%0d out_src", k),   32'(bus.out_src),   32'(k % 4));
         chk($sformatf("fair%0d out_data", k),  32'(bus.out_data),  32'(k % 4));
         $display("fair%0d out_src=%0d out_data=%h", k, bus.out_src, bus.out_data);
      end

      // Stall: hold 1111 for three cycles, then source 2 wins on release.
      do_reset();
      set_in(4'b0010, 16'h0, 16'h1111, 16'h0, 16'h0, 1'b1);
      tick();
      chk("stall load out_data", 32'(bus.out_data), 32'h1111);
      set_in(4'b1111, 16'hE000, 16'hE001, 16'hE002, 16'hE003, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
         tick();
         chk($sformatf("stall%0d out_data", k), 32'(bus.out_data), 32'h1111);
         $display("stall%0d in_ready=%b out_data=%h", k, bus.in_ready, bus.out_data);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("stall release in_ready", 32'(bus.in_ready), 32'b0100);
      tick();
      chk("stall release out_src",  32'(bus.out_src),  32'd2);
      chk("stall release out_data", 32'(bus.out_data), 32'hE002);
      $display("stall release out_src=%0d out_data=%h", bus.out_src, bus.out_data);

      // Asynchronous reset between edges while a word is held.
      do_reset();
      set_in(4'b0001, 16'h7777, 16'h0, 16'h0, 16'h0, 1'b1);
      tick();
      chk("areset pre out_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("areset out_valid", 32'(bus.out_valid), 32'd0);
      chk("areset out_data",  32'(bus.out_data),  32'd0);
      #1;
      rst = 1'b0;
      set_in(4'b1111, 16'h0, 16'h0, 16'h0, 16'h3333, 1'b1);
      #1;
      chk("areset ptr0 in_ready", 32'(bus.in_ready), 32'b0001);
      bus.in_valid = 4'b1000;
      #1;
      chk("areset src3 in_ready", 32'(bus.in_ready), 32'b1000);
      tick();
      chk("areset src3 out_src",   32'(bus.out_src),   32'd3);
      chk("areset src3 out_valid", 32'(bus.out_valid), 32'd1);
      chk("areset src3 out_data",  32'(bus.out_data),  32'h3333);
      $display("areset out_src=%0d out_data=%h", bus.out_src, bus.out_data);

`ifdef ARB4_BURST_LOCK_EN
      // Burst: source 0 holds the grant for three beats while source 1 waits.
      do_reset();
      set_in(4'b0011, 16'h0B00, 16'h0B01, 16'h0, 16'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         bus.in_last = (k == 2) ? 4'b0001 : ((k == 3) ? 4'b0011 : 4'b0000);
         bus.in_data_0 = 16'h0B00 + 16'(k);
         #1;
         chk($sformatf("burst%0d in_ready", k), 32'(bus.in_ready), (k < 3) ? 32'b0001 : 32'b0010);
         tick();
         chk($sformatf("burst%0d out_src", k), 32'(bus.out_src), (k < 3) ? 32'd0 : 32'd1);
         $display("burst%0d in_last=%b out_src=%0d out_data=%h", k, bus.in_last, bus.out_src, bus.out_data);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/arb4_rr_stage.md
Name: arb4_rr_stage

Overview:
- Four-source round-robin arbiter with a registered output stage; a neighbouring stage to the 4:1 datapath mux.
- Generates the 2-bit source select.
- Steers the chosen source through an internal mux4_nbit instance.
- Presents one valid/ready stream downstream.
- Sits between four producer units (e.g. ALU, memory, immediate, PC paths) and the single write-back/consumer port.

Parameters:
- DataWidth, 16, width of each source data word and of out_data.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-source valid; bit i = source i.
- in_data_0..in_data_3  input  DataWidth each  source payloads.
- in_ready  output  4  per-source accept; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  DataWidth  registered selected payload.
- out_src  output  2  registered index of the source that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0, so source 0 has highest priority.
  - Lock state = IDLE.
- can_load = !out_valid | out_ready. This is a combinational path from out_ready to in_ready, by design.
- Grant:
  - Search sources ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first with in_valid=1.
  - grant_idx is the 2-bit result; any_req = |in_valid.
  - The pointer arithmetic wraps modulo 4 (3+1 -> 0).
- Handshakes:
  - in_ready[i] = can_load & any_req & (grant_idx==i). Every other bit is 0.
  - Transfer from source i occurs when in_valid[i] & in_ready[i].
- On a transfer, at the next edge:
  - out_data <= in_data_[grant_idx], selected via mux4_nbit with select=grant_idx.
  - out_src <= grant_idx, out_valid <= 1.
  - ptr <= grant_idx+1.
- Drain without a new transfer: out_ready & out_valid & no input transfer -> out_valid <= 0. out_data and out_src hold.
- Stall: out_valid & !out_ready -> the output register holds, all in_ready=0, ptr holds.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous drain and load in the same cycle: new word replaces the old with no bubble; out_valid stays 1.
- Sources are not required to hold valid while not granted. A dropped request simply drops out of the search.
- Reset mid-operation: the held word is discarded, out_valid -> 0 immediately (async), ptr -> 0.
- Fairness: with all four continuously requesting and out_ready=1, grants cycle 0,1,2,3,0,... No source waits more than 3 transfers.

Optional Feature:
- Macro: ARB4_BURST_LOCK_EN.
- When defined:
  - Adds port in_last (input, 4 bits), per-source end-of-burst flag.
  - Adds a 2-state FSM:
    - IDLE: grants round-robin as above.
    - LOCKED: grant is forced to lock_idx; the search is bypassed, and in_ready is only asserted for lock_idx.
  - IDLE -> LOCKED: on a transfer with in_last[grant_idx]=0; lock_idx <= grant_idx.
  - LOCKED -> IDLE: on a transfer with in_last[lock_idx]=1.
  - ptr updates only on the transfer that returns the FSM to IDLE (lock_idx+1).
  - A single-beat burst (last=1 on the first beat) stays in IDLE.
  - Reset forces IDLE.
- When not defined: no in_last port, no FSM, and every beat is independently arbitrated.

Decomposition:
- Package kolum_arb_pkg contains:
  - NUM_SRC=4, SRC_W=2.
  - Typedef src_idx_t (logic [SRC_W-1:0]).
  - Enum lock_state_t {LK_IDLE, LK_LOCKED}.
- Sub-module rr_pick4: combinational rotate-priority picker. Inputs req[3:0] and ptr[1:0]; outputs grant_idx and any_req.
- Data steering reuses the existing mux4_nbit with MuxWidth=DataWidth.

Test Plan:
1. Reset then single request: in_valid=4'b0100, in_data_2=16'hBEEF, out_ready=1.
   - Required: in_ready=4'b0100.
   - Next cycle: out_valid=1, out_data=16'hBEEF, out_src=2.
   - ptr=3, observed via the next grant.
2. All four requesting for 8 cycles with out_ready=1, data = source index.
   - Required: out_src sequence 0,1,2,3,0,1,2,3, one word per cycle, no bubbles.
3. Stall: load source 1 (16'h1111), then out_ready=0 for 3 cycles while in_valid=4'b1111.
   - Required: out_data stays 16'h1111 and in_ready=0 throughout.
   - When out_ready returns to 1: source 2 is granted in that same cycle.
4. Async reset mid-stream: assert rst between clock edges while out_valid=1.
   - Required: out_valid=0 immediately.
   - After release with in_valid=4'b1000: source 3 is granted, since it is the only requester.
5. ARB4_BURST_LOCK_EN defined:
   - Stimulus: source 0 sends a 3-beat burst (last only on beat 3) while source 1 requests continuously.
   - Required: out_src 0,0,0, then 1; in_ready[1]=0 during the burst.
